mod_counter: RTL and testbench

- Parametrised up/down modulo counter; next generation of the team's 8-bit free-running counter.
- Adds width/modulus parameters, direction control, synchronous load and clear, an enable prescaler, a saturate-vs-wrap mode and a terminal-count pulse.
- Used as the general event/timebase counter in datapath and test designs.

---
 rtl/mod_counter_pkg.sv | 19 +
 rtl/mod_counter_if.sv | 22 ++
 rtl/mod_counter_prescaler.sv | 29 ++
 rtl/mod_counter.sv | 98 +++++++++
 tb/tb_mod_counter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants, mode encoding and load-clamp helper for the modulo counter.
package mod_counter_pkg;

    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } mode_e;

    // Clamp a loaded value to the top of the count range; one extra bit keeps MODULO = 2**WIDTH safe.
    function automatic logic [WIDTH_MAX:0] clamp_load(
        input logic [WIDTH_MAX:0] val,
        input logic [WIDTH_MAX:0] lim
    );
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface mod_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] value;
    logic             tc;

    modport master (
        output en, up, clear, load, load_value,
        input  value, tc
    );

    modport slave (
        input  en, up, clear, load, load_value,
        output value, tc
    );
endinterface

// File: rtl/mod_counter_prescaler.sv
// Enable prescaler: emits one step per PRESCALE enabled cycles; restart forces phase 0.
module mod_counter_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic step
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase;

    assign step = en && (phase == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
        end else if (restart) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : CW'(phase + 1'b1);
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with load/clear, prescaled enable,
// wrap-or-saturate boundaries and a registered terminal-count pulse.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned       WIDTH    = 8,
    parameter longint unsigned   MODULO   = 256,
    parameter int unsigned       SATURATE = 0,
    parameter int unsigned       PRESCALE = 1
) (
    input  logic          clk,
    input  logic          reset,
    mod_counter_if.slave  bus
);

    // Top of range held at WIDTH+1 bits so MODULO = 2**WIDTH cannot overflow.
    localparam logic [WIDTH:0]   MAX_WIDE = (WIDTH + 1)'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] MAX_VAL  = MAX_WIDE[WIDTH-1:0];
    localparam mode_e            MODE     = (SATURATE != 0) ? SAT : WRAP;

    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "mod_counter: WIDTH=%0d outside 2..%0d", WIDTH, WIDTH_MAX);
    end
    if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
        $fatal(1, "mod_counter: MODULO=%0d outside 2..2**WIDTH", MODULO);
    end
    if (SATURATE > 1) begin : g_bad_sat
        $fatal(1, "mod_counter: SATURATE=%0d must be 0 or 1", SATURATE);
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $fatal(1, "mod_counter: PRESCALE=%0d outside 1..65535", PRESCALE);
    end

    logic             step;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_zero;

    mod_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.en),
        .restart (bus.clear | bus.load),
        .step    (step)
    );

    assign load_clamped = WIDTH'(clamp_load((WIDTH_MAX + 1)'(bus.load_value),
                                            (WIDTH_MAX + 1)'(MAX_WIDE)));
    assign at_max  = (value_q == MAX_VAL);
    assign at_zero = (value_q == '0);

    // Next value and terminal count: clear beats load beats step.
    always_comb begin
        value_d = value_q;
        tc_d    = 1'b0;
        if (bus.clear) begin
            value_d = '0;
        end else if (bus.load) begin
            value_d = load_clamped;
        end else if (step) begin
            if (bus.up) begin
                if (at_max) begin
                    tc_d = 1'b1;
                    if (MODE == WRAP) value_d = '0;
                end else begin
                    value_d = value_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    tc_d = 1'b1;
                    if (MODE == WRAP) value_d = MAX_VAL;
                end else begin
                    value_d = value_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            value_q <= value_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.value = value_q;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter across several parameter sets sharing one clock and reset.
module tb_mod_counter;

    logic clk;
    logic reset;

    int tests;
    int fails;

    mod_counter_if #(.WIDTH(8)) a_if ();
    mod_counter_if #(.WIDTH(8)) b_if ();
    mod_counter_if #(.WIDTH(8)) c_if ();
    mod_counter_if #(.WIDTH(8)) d_if ();
    mod_counter_if #(.WIDTH(2)) e_if ();

    mod_counter #(.WIDTH(8), .MODULO(256), .SATURATE(0), .PRESCALE(1))
        u_a (.clk(clk), .reset(reset), .bus(a_if));
    mod_counter #(.WIDTH(8), .MODULO(10), .SATURATE(0), .PRESCALE(1))
        u_b (.clk(clk), .reset(reset), .bus(b_if));
    mod_counter #(.WIDTH(8), .MODULO(10), .SATURATE(1), .PRESCALE(1))
        u_c (.clk(clk), .reset(reset), .bus(c_if));
    mod_counter #(.WIDTH(8), .MODULO(256), .SATURATE(0), .PRESCALE(3))
        u_d (.clk(clk), .reset(reset), .bus(d_if));
    mod_counter #(.WIDTH(2), .MODULO(2), .SATURATE(0), .PRESCALE(1))
        u_e (.clk(clk), .reset(reset), .bus(e_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        a_if.en = 0; a_if.up = 0; a_if.clear = 0; a_if.load = 0; a_if.load_value = '0;
        b_if.en = 0; b_if.up = 0; b_if.clear = 0; b_if.load = 0; b_if.load_value = '0;
        c_if.en = 0; c_if.up = 0; c_if.clear = 0; c_if.load = 0; c_if.load_value = '0;
        d_if.en = 0; d_if.up = 0; d_if.clear = 0; d_if.load = 0; d_if.load_value = '0;
        e_if.en = 0; e_if.up = 0; e_if.clear = 0; e_if.load = 0; e_if.load_value = '0;

        #2;
        check("reset_value", 32'(a_if.value), 32'd0);
        check("reset_tc", 32'(a_if.tc), 32'd0);
        #15;
        reset = 1'b1;

        // Free-running up count through the 256 wrap
        a_if.en = 1; a_if.up = 1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            check("a_count", 32'(a_if.value), 32'(i));
            check("a_count_tc", 32'(a_if.tc), 32'd0);
        end
        tick();
        check("a_wrap_value", 32'(a_if.value), 32'd0);
        check("a_wrap_tc", 32'(a_if.tc), 32'd1);
        tick();
        check("a_after_wrap_value", 32'(a_if.value), 32'd1);
        check("a_after_wrap_tc", 32'(a_if.tc), 32'd0);

        // Load with en: loaded value, no step, no tc
        a_if.load = 1; a_if.load_value = 8'h37;
        tick();
        check("a_load_en_value", 32'(a_if.value), 32'h37);
        check("a_load_en_tc", 32'(a_if.tc), 32'd0);

        // Clear beats load
        a_if.clear = 1; a_if.load_value = 8'd5;
        tick();
        check("a_clear_load", 32'(a_if.value), 32'd0);
        a_if.clear = 0; a_if.load = 0; a_if.en = 0;

        // Modulo-10 down count from 0
        b_if.en = 1; b_if.up = 0;
        tick();
        check("b_under_value", 32'(b_if.value), 32'd9);
        check("b_under_tc", 32'(b_if.tc), 32'd1);
        for (int v = 8; v >= 0; v--) begin
            tick();
            check("b_down", 32'(b_if.value), 32'(v));
            check("b_down_tc", 32'(b_if.tc), 32'd0);
        end
        tick();
        check("b_wrap2_value", 32'(b_if.value), 32'd9);
        check("b_wrap2_tc", 32'(b_if.tc), 32'd1);
        b_if.en = 0;
        tick();
        check("b_idle_tc", 32'(b_if.tc), 32'd0);

        // Load above range clamps to MODULO-1
        b_if.load = 1; b_if.load_value = 8'hC8;
        b_if.en = 1; b_if.up = 0;
        tick();
        check("b_clamp", 32'(b_if.value), 32'd9);
        check("b_clamp_tc", 32'(b_if.tc), 32'd0);
        b_if.load = 0; b_if.en = 0;

        // Saturating up count holds at 9 with tc held while enabled
        c_if.en = 1; c_if.up = 1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("c_up", 32'(c_if.value), 32'(i));
            check("c_up_tc", 32'(c_if.tc), 32'd0);
        end
        tick();
        check("c_hold1", 32'(c_if.value), 32'd9);
        check("c_hold1_tc", 32'(c_if.tc), 32'd1);
        tick();
        check("c_hold2", 32'(c_if.value), 32'd9);
        check("c_hold2_tc", 32'(c_if.tc), 32'd1);
        c_if.en = 0;
        tick();
        check("c_off_value", 32'(c_if.value), 32'd9);
        check("c_off_tc", 32'(c_if.tc), 32'd0);

        // Prescale-by-3 with en pattern 1,1,0,1
        d_if.up = 1;
        d_if.en = 1; tick(); check("d_p1", 32'(d_if.value), 32'd0);
        d_if.en = 1; tick(); check("d_p2", 32'(d_if.value), 32'd0);
        d_if.en = 0; tick(); check("d_p3", 32'(d_if.value), 32'd0);
        d_if.en = 1; tick(); check("d_p4", 32'(d_if.value), 32'd1);
        tick(); check("d_mid", 32'(d_if.value), 32'd1);
        // Load mid-phase restarts the phase
        d_if.load = 1; d_if.load_value = 8'd20;
        tick(); check("d_load", 32'(d_if.value), 32'd20);
        d_if.load = 0;
        tick(); check("d_after1", 32'(d_if.value), 32'd20);
        tick(); check("d_after2", 32'(d_if.value), 32'd20);
        tick(); check("d_after3", 32'(d_if.value), 32'd21);
        d_if.en = 0;

        // MODULO = 2 alternates with tc on each 1->0
        e_if.en = 1; e_if.up = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("e_value", 32'(e_if.value), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("e_tc", 32'(e_if.tc), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        e_if.en = 0;

        // Asynchronous reset mid-count, then resume from 0
        a_if.en = 1; a_if.up = 1;
        tick();
        tick();
        check("a_pre_reset", 32'(a_if.value), 32'd2);
        #3;
        reset = 1'b0;
        #1;
        check("a_async_reset", 32'(a_if.value), 32'd0);
        check("d_async_reset", 32'(d_if.value), 32'd0);
        #1;
        reset = 1'b1;
        tick();
        check("a_resume", 32'(a_if.value), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
